// File: rtl/updown_pulse_pkg.sv
// Shared types for the up/down pushbutton front end: the command FSM state
// encoding and the record of which button owns the current press.
package updown_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_DLY = 2'd1,
    HOLD_RPT = 2'd2,
    LOCK     = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/updown_pulse_gen_btn_debounce.sv
// One pushbutton channel: two-flop synchroniser followed by a debouncer that
// only accepts a new level after it has been seen DB_CYCLES cycles in a row.
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise the raw pin, then count consecutive disagreeing cycles and
  // adopt the synchronised level once the count completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync   <= 2'b00;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/updown_pulse_gen.sv
// Turns two bouncing pushbuttons into clean, single-cycle, mutually exclusive
// up/down command pulses with optional auto-repeat while a button is held.
// Pressing both buttons locks the generator out until both are released.
module updown_pulse_gen
  import updown_pulse_pkg::*;
#(
  parameter int DB_CYCLES    = 16,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16,
  parameter int TMR_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic rpt_en,
  output logic up,
  output logic down,
  output logic held
);

  localparam logic [TMR_W-1:0] DLY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LAST = TMR_W'(REPEAT_RATE - 1);

  logic             w_stableUp;
  logic             w_stableDown;
  logic             w_activeLvl;
  logic             w_otherLvl;
  logic             w_pulse;
  state_t           w_nextState;
  dir_t             w_nextDir;
  logic [TMR_W-1:0] w_nextTmr;

  state_t           r_state;
  dir_t             r_dir;
  logic [TMR_W-1:0] r_tmr;
  logic             r_up;
  logic             r_down;
  logic             r_held;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dbUp (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (btn_up),
    .o_stable (w_stableUp)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dbDown (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (btn_down),
    .o_stable (w_stableDown)
  );

  // Decide the next state, timer value and whether a command pulse is due;
  // a competing press beats a release, and a release beats a due repeat.
  always_comb begin
    w_nextState = r_state;
    w_nextDir   = r_dir;
    w_nextTmr   = r_tmr;
    w_pulse     = 1'b0;
    w_activeLvl = (r_dir == DIR_UP) ? w_stableUp : w_stableDown;
    w_otherLvl  = (r_dir == DIR_UP) ? w_stableDown : w_stableUp;

    case (r_state)
      IDLE: begin
        w_nextTmr = '0;
        if (w_stableUp && w_stableDown) begin
          w_nextState = LOCK;
        end else if (w_stableUp) begin
          w_pulse     = 1'b1;
          w_nextDir   = DIR_UP;
          w_nextState = HOLD_DLY;
        end else if (w_stableDown) begin
          w_pulse     = 1'b1;
          w_nextDir   = DIR_DOWN;
          w_nextState = HOLD_DLY;
        end
      end

      HOLD_DLY: begin
        if (w_otherLvl) begin
          w_nextState = LOCK;
        end else if (!w_activeLvl) begin
          w_nextState = IDLE;
        end else if (r_tmr == DLY_LAST) begin
          // With repeat disabled the timer parks here until release.
          if (rpt_en) begin
            w_pulse     = 1'b1;
            w_nextTmr   = '0;
            w_nextState = HOLD_RPT;
          end
        end else begin
          w_nextTmr = r_tmr + TMR_W'(1);
        end
      end

      HOLD_RPT: begin
        if (w_otherLvl) begin
          w_nextState = LOCK;
        end else if (!w_activeLvl) begin
          w_nextState = IDLE;
        end else if (r_tmr == RATE_LAST) begin
          if (rpt_en) begin
            w_pulse   = 1'b1;
            w_nextTmr = '0;
          end
        end else begin
          w_nextTmr = r_tmr + TMR_W'(1);
        end
      end

      LOCK: begin
        w_nextTmr = '0;
        if (!w_stableUp && !w_stableDown) begin
          w_nextState = IDLE;
        end
      end

      default: begin
        w_nextState = IDLE;
        w_nextTmr   = '0;
      end
    endcase
  end

  // Register FSM state and the command outputs so they leave glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_dir   <= DIR_UP;
      r_tmr   <= '0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_dir   <= w_nextDir;
      r_tmr   <= w_nextTmr;
      r_up    <= w_pulse && (w_nextDir == DIR_UP);
      r_down  <= w_pulse && (w_nextDir == DIR_DOWN);
      r_held  <= (r_state == HOLD_DLY) || (r_state == HOLD_RPT);
    end
  end

  assign up   = r_up;
  assign down = r_down;
  assign held = r_held;

endmodule

// File: tb/tb_updown_pulse_gen.sv
// Directed bench for updown_pulse_gen with short debounce/repeat timings.
// Expected pulse positions are hand-computed: a steady press driven just
// after edge 0 produces a pulse visible after edge 7 (2 sync + 4 debounce + 1).
module tb_updown_pulse_gen;

  logic clk = 1'b0;
  logic reset;
  logic btnUp;
  logic btnDown;
  logic rptEn;
  logic up;
  logic down;
  logic held;

  int testsRun = 0;
  int testsFailed = 0;
  int overlapCount = 0;

  logic upLog   [0:127];
  logic downLog [0:127];
  logic heldLog [0:127];

  updown_pulse_gen #(
    .DB_CYCLES    (4),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (5),
    .TMR_W        (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btnUp),
    .btn_down (btnDown),
    .rpt_en   (rptEn),
    .up       (up),
    .down     (down),
    .held     (held)
  );

  always #5 clk = ~clk;

  // Watch every cycle for both commands being high together.
  always @(negedge clk) begin
    if (up === 1'b1 && down === 1'b1) overlapCount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      tick();
      upLog[k]   = up;
      downLog[k] = down;
      heldLog[k] = held;
    end
  endtask

  function automatic int countUp(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (upLog[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int countDown(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (downLog[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int countHeld(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (heldLog[k] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    reset = 1'b1; btnUp = 1'b0; btnDown = 1'b0; rptEn = 1'b0;
    repeat (3) tick();
    testsRun++; if (up !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_up: got %b want 0", up); end
    testsRun++; if (down !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_down: got %b want 0", down); end
    testsRun++; if (held !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_held: got %b want 0", held); end
    reset = 1'b0;
    runCycles(1, 10);
    testsRun++; if (countUp(1, 10) + countDown(1, 10) !== 0) begin testsFailed++; $display("[TB] FAIL idle_no_pulse: got %0d pulses want 0", countUp(1, 10) + countDown(1, 10)); end
  endtask

  task automatic test_single_press();
    rptEn = 1'b0;
    btnUp = 1'b1;
    runCycles(1, 40);
    testsRun++; if (upLog[6] !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_up_early: got %b want 0", upLog[6]); end
    testsRun++; if (upLog[7] !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_up_latency: got %b want 1", upLog[7]); end
    testsRun++; if (upLog[8] !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_up_width: got %b want 0", upLog[8]); end
    testsRun++; if (countUp(1, 40) !== 1) begin testsFailed++; $display("[TB] FAIL single_up_count: got %0d want 1", countUp(1, 40)); end
    testsRun++; if (countDown(1, 40) !== 0) begin testsFailed++; $display("[TB] FAIL single_down_quiet: got %0d want 0", countDown(1, 40)); end
    testsRun++; if (heldLog[7] !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_held_before: got %b want 0", heldLog[7]); end
    testsRun++; if (heldLog[8] !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_held_rise: got %b want 1", heldLog[8]); end
    testsRun++; if (heldLog[40] !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_held_late: got %b want 1", heldLog[40]); end
    btnUp = 1'b0;
    runCycles(1, 15);
    testsRun++; if (heldLog[15] !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_release_held: got %b want 0", heldLog[15]); end
    testsRun++; if (countUp(1, 15) !== 0) begin testsFailed++; $display("[TB] FAIL single_release_pulse: got %0d want 0", countUp(1, 15)); end
  endtask

  task automatic test_bounce();
    rptEn = 1'b0;
    btnDown = 1'b1; runCycles(1, 1);
    btnDown = 1'b0; runCycles(2, 2);
    btnDown = 1'b1; runCycles(3, 3);
    btnDown = 1'b0; runCycles(4, 4);
    btnDown = 1'b1; runCycles(5, 25);
    testsRun++; if (countDown(1, 10) !== 0) begin testsFailed++; $display("[TB] FAIL bounce_early_pulse: got %0d want 0", countDown(1, 10)); end
    testsRun++; if (downLog[11] !== 1'b1) begin testsFailed++; $display("[TB] FAIL bounce_down_latency: got %b want 1", downLog[11]); end
    testsRun++; if (countDown(1, 25) !== 1) begin testsFailed++; $display("[TB] FAIL bounce_down_count: got %0d want 1", countDown(1, 25)); end
    testsRun++; if (countUp(1, 25) !== 0) begin testsFailed++; $display("[TB] FAIL bounce_up_quiet: got %0d want 0", countUp(1, 25)); end
    btnDown = 1'b0;
    runCycles(1, 15);
  endtask

  task automatic test_auto_repeat();
    rptEn = 1'b1;
    btnUp = 1'b1;
    runCycles(1, 35);
    // Released so the debounced level falls exactly when the next repeat is due.
    btnUp = 1'b0;
    runCycles(36, 60);
    testsRun++; if (upLog[7] !== 1'b1) begin testsFailed++; $display("[TB] FAIL rpt_first: got %b want 1", upLog[7]); end
    testsRun++; if (upLog[26] !== 1'b0) begin testsFailed++; $display("[TB] FAIL rpt_delay_early: got %b want 0", upLog[26]); end
    testsRun++; if (upLog[27] !== 1'b1) begin testsFailed++; $display("[TB] FAIL rpt_delay: got %b want 1", upLog[27]); end
    testsRun++; if (upLog[32] !== 1'b1) begin testsFailed++; $display("[TB] FAIL rpt_rate1: got %b want 1", upLog[32]); end
    testsRun++; if (upLog[37] !== 1'b1) begin testsFailed++; $display("[TB] FAIL rpt_rate2: got %b want 1", upLog[37]); end
    testsRun++; if (upLog[42] !== 1'b0) begin testsFailed++; $display("[TB] FAIL rpt_release_wins: got %b want 0", upLog[42]); end
    testsRun++; if (countUp(1, 60) !== 4) begin testsFailed++; $display("[TB] FAIL rpt_count: got %0d want 4", countUp(1, 60)); end
    testsRun++; if (countDown(1, 60) !== 0) begin testsFailed++; $display("[TB] FAIL rpt_down_quiet: got %0d want 0", countDown(1, 60)); end
    testsRun++; if (heldLog[42] !== 1'b1) begin testsFailed++; $display("[TB] FAIL rpt_held_last: got %b want 1", heldLog[42]); end
    testsRun++; if (heldLog[43] !== 1'b0) begin testsFailed++; $display("[TB] FAIL rpt_held_drop: got %b want 0", heldLog[43]); end
  endtask

  task automatic test_lock();
    rptEn = 1'b1;
    btnUp = 1'b1; btnDown = 1'b1;
    runCycles(1, 30);
    testsRun++; if (countUp(1, 30) + countDown(1, 30) !== 0) begin testsFailed++; $display("[TB] FAIL lock_both_pulses: got %0d want 0", countUp(1, 30) + countDown(1, 30)); end
    testsRun++; if (countHeld(1, 30) !== 0) begin testsFailed++; $display("[TB] FAIL lock_both_held: got %0d want 0", countHeld(1, 30)); end
    btnUp = 1'b0;
    runCycles(1, 20);
    testsRun++; if (countUp(1, 20) + countDown(1, 20) !== 0) begin testsFailed++; $display("[TB] FAIL lock_one_left: got %0d want 0", countUp(1, 20) + countDown(1, 20)); end
    btnDown = 1'b0;
    runCycles(1, 12);
    btnUp = 1'b1;
    runCycles(1, 12);
    testsRun++; if (upLog[7] !== 1'b1) begin testsFailed++; $display("[TB] FAIL lock_exit_press: got %b want 1", upLog[7]); end
    testsRun++; if (countUp(1, 12) !== 1) begin testsFailed++; $display("[TB] FAIL lock_exit_count: got %0d want 1", countUp(1, 12)); end
    btnUp = 1'b0;
    runCycles(1, 15);
  endtask

  task automatic test_back_to_back();
    rptEn = 1'b1;
    btnUp = 1'b1;
    runCycles(1, 30);
    btnDown = 1'b1;
    runCycles(31, 60);
    testsRun++; if (upLog[32] !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_repeat_before: got %b want 1", upLog[32]); end
    testsRun++; if (upLog[37] !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_repeat_stopped: got %b want 0", upLog[37]); end
    testsRun++; if (countUp(33, 60) !== 0) begin testsFailed++; $display("[TB] FAIL b2b_up_after: got %0d want 0", countUp(33, 60)); end
    testsRun++; if (countDown(1, 60) !== 0) begin testsFailed++; $display("[TB] FAIL b2b_no_down: got %0d want 0", countDown(1, 60)); end
    testsRun++; if (heldLog[37] !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_held_last: got %b want 1", heldLog[37]); end
    testsRun++; if (heldLog[38] !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_held_drop: got %b want 0", heldLog[38]); end
    btnUp = 1'b0; btnDown = 1'b0;
    runCycles(1, 15);
  endtask

  task automatic test_reset_mid_hold();
    rptEn = 1'b1;
    btnUp = 1'b1;
    runCycles(1, 32);
    testsRun++; if (upLog[32] !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_pre_pulse: got %b want 1", upLog[32]); end
    reset = 1'b1;
    #1;
    testsRun++; if (up !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_async_up: got %b want 0", up); end
    testsRun++; if (down !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_async_down: got %b want 0", down); end
    testsRun++; if (held !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_async_held: got %b want 0", held); end
    tick();
    tick();
    reset = 1'b0;
    runCycles(1, 15);
    testsRun++; if (upLog[6] !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_repress_early: got %b want 0", upLog[6]); end
    testsRun++; if (upLog[7] !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_repress_pulse: got %b want 1", upLog[7]); end
    testsRun++; if (countUp(1, 15) !== 1) begin testsFailed++; $display("[TB] FAIL rst_repress_count: got %0d want 1", countUp(1, 15)); end
    btnUp = 1'b0;
    runCycles(1, 15);
  endtask

  task automatic test_exclusive();
    testsRun++; if (overlapCount !== 0) begin testsFailed++; $display("[TB] FAIL exclusive: got %0d overlapping cycles want 0", overlapCount); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_auto_repeat();
    test_lock();
    test_back_to_back();
    test_reset_mid_hold();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
